// File: rtl/ser_pkg.sv
// Shared definitions for the serializer arbiter: default sizes, FSM states
// and the bit counts the downstream serializer cannot handle.
package ser_pkg;

    localparam int unsigned DEF_N_REQ  = 4;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_MOD_W  = 4;

    localparam int unsigned MOD_ILLEGAL_A = 1;
    localparam int unsigned MOD_ILLEGAL_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic logic mod_is_illegal(input logic [31:0] mod);
        return (mod == MOD_ILLEGAL_A) || (mod == MOD_ILLEGAL_B);
    endfunction

endpackage

// File: rtl/ser_arbiter_rr.sv
// Combinational round-robin selector: the first active request strictly
// after the pointer position wins, wrapping from N_REQ-1 back to 0.
module rr_arbiter
    import ser_pkg::*;
#(
    parameter  int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // offset N_REQ lands back on the pointer itself, so it has lowest priority
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((32'(ptr_i) + off) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser_arbiter.sv
// Arbitrates N_REQ word sources onto one serializer: round-robin accept,
// drop unsupported bit counts, issue a start strobe, wait for the serializer.
module ser_arbiter
    import ser_pkg::*;
#(
    parameter  int unsigned N_REQ  = DEF_N_REQ,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned MOD_W  = DEF_MOD_W,
    localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic [N_REQ-1:0]             req_val_i,
    input  logic [N_REQ-1:0][DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0][MOD_W-1:0]  req_mod_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic [DATA_W-1:0]            ser_data_o,
    output logic [MOD_W-1:0]             ser_mod_o,
    output logic                         ser_val_o,
    input  logic                         ser_busy_i,
    output logic [IDX_W-1:0]             grant_id_o,
    output logic                         drop_o,
    output logic                         busy_o
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic              drop_q, drop_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req_i (req_val_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        mod_d       = mod_q;
        grant_d     = grant_q;
        drop_d      = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any && !ser_busy_i) begin
                    req_ready_o = arb_gnt;
                    ptr_d       = arb_idx;
                    data_d      = req_data_i[arb_idx];
                    mod_d       = req_mod_i[arb_idx];
                    if (mod_is_illegal(32'(req_mod_i[arb_idx]))) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        grant_d = arb_idx;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!ser_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // ready is combinational, so it must be masked while reset is held
        if (!arst_n_i) begin
            req_ready_o = '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            data_q  <= '0;
            mod_q   <= '0;
            grant_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            grant_q <= grant_d;
            drop_q  <= drop_d;
        end
    end

    assign ser_val_o  = (state_q == ST_ISSUE);
    assign busy_o     = (state_q != ST_IDLE);
    assign ser_data_o = data_q;
    assign ser_mod_o  = mod_q;
    assign grant_id_o = grant_q;
    assign drop_o     = drop_q;

endmodule

// File: tb/tb_ser_arbiter.sv
// Self-checking bench for ser_arbiter with a serializer model and a
// scoreboard of accepted words compared at each start strobe.
module tb_ser_arbiter;
    import ser_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned MW = 4;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic [NR-1:0]        req_val;
    logic [NR-1:0][DW-1:0] req_data;
    logic [NR-1:0][MW-1:0] req_mod;
    logic [NR-1:0]        req_ready;
    logic [DW-1:0]        ser_data;
    logic [MW-1:0]        ser_mod;
    logic                 ser_val;
    logic                 ser_busy;
    logic [1:0]           grant_id;
    logic                 drop;
    logic                 busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ser_arbiter #(
        .N_REQ  (NR),
        .DATA_W (DW),
        .MOD_W  (MW)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .req_val_i   (req_val),
        .req_data_i  (req_data),
        .req_mod_i   (req_mod),
        .req_ready_o (req_ready),
        .ser_data_o  (ser_data),
        .ser_mod_o   (ser_mod),
        .ser_val_o   (ser_val),
        .ser_busy_i  (ser_busy),
        .grant_id_o  (grant_id),
        .drop_o      (drop),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Serializer model: shifts one bit per cycle for n cycles after the
    // strobe; busy drops during the final bit.
    logic [4:0]    sm_cnt;
    logic [DW-1:0] sm_sh;
    logic [DW-1:0] sm_rx;
    logic          sm_done;
    assign ser_busy = (sm_cnt > 5'd1);

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sm_cnt <= '0; sm_sh <= '0; sm_rx <= '0; sm_done <= 1'b0;
        end else if (ser_val) begin
            sm_cnt  <= (ser_mod == '0) ? 5'd16 : {1'b0, ser_mod};
            sm_sh   <= ser_data;
            sm_rx   <= '0;
            sm_done <= 1'b0;
        end else if (sm_cnt != '0) begin
            sm_rx   <= {sm_rx[DW-2:0], sm_sh[DW-1]};
            sm_sh   <= sm_sh << 1;
            sm_cnt  <= sm_cnt - 5'd1;
            sm_done <= (sm_cnt == 5'd1);
        end else begin
            sm_done <= 1'b0;
        end
    end

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic [MW-1:0] mod;
    } sb_t;
    sb_t         sb_q[$];
    logic [31:0] exp_bits;

    // Monitor samples 2 ns before each rising edge.
    always @(negedge clk) begin
        #3;
        if (!arst_n) begin
            sb_q.delete();
        end else begin
            if (req_ready != '0) begin
                check("ready_onehot", 32'($countones(req_ready)), 32'd1);
                check("ready_subset_of_val", 32'(req_ready & ~req_val), 32'd0);
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i] && req_val[i] && req_mod[i] != 4'd1 && req_mod[i] != 4'd2) begin
                        sb_t e;
                        e.id = 2'(i); e.data = req_data[i]; e.mod = req_mod[i];
                        sb_q.push_back(e);
                    end
                end
            end
            if (ser_val) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: ser_val_o with no accepted word pending");
                end else begin
                    sb_t e;
                    int  n;
                    e = sb_q.pop_front();
                    check("sb_grant_id", 32'(grant_id), 32'(e.id));
                    check("sb_ser_data", 32'(ser_data), 32'(e.data));
                    check("sb_ser_mod", 32'(ser_mod), 32'(e.mod));
                    n = (e.mod == '0) ? 16 : int'(e.mod);
                    exp_bits = 32'(e.data) >> (16 - n);
                end
            end
            if (sm_done) check("serial_bits", 32'(sm_rx), exp_bits);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || ser_busy) && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) begin
            n_checks++;
            $display("FAIL %s: timeout waiting for idle, busy=%0b", name, busy);
        end
    endtask

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        logic [MW-1:0] mod;
        logic          drop;
        int            wait_n;
    } vec_t;
    vec_t vt[6];

    int   exp_ids[5] = '{0, 1, 2, 3, 0};
    int   got_ids[5];
    int   got_cyc[5];
    int   np, cy, cnt;
    logic hold_ok;
    logic [NR-1:0] acc_ready;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_val = '0; req_data = '0; req_mod = '0;
        vt[0] = '{2, 16'hA5C3, 4'd0,  1'b0, 16};
        vt[1] = '{1, 16'hFFFF, 4'd2,  1'b1, 0};
        vt[2] = '{0, 16'h1234, 4'd15, 1'b0, 15};
        vt[3] = '{3, 16'h8001, 4'd3,  1'b0, 3};
        vt[4] = '{2, 16'h5555, 4'd1,  1'b1, 0};
        vt[5] = '{1, 16'hF0F0, 4'd4,  1'b0, 4};

        // Reset values, with every requester valid to show ready is masked
        step();
        req_val = '1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ser_val", 32'(ser_val), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_ser_data", 32'(ser_data), 32'd0);
        check("rst_ser_mod", 32'(ser_mod), 32'd0);
        req_val = '0;
        step();
        arst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            wait_idle($sformatf("vec%0d_pre", v));
            req_val = '0;
            req_val[vt[v].id]  = 1'b1;
            req_data[vt[v].id] = vt[v].data;
            req_mod[vt[v].id]  = vt[v].mod;
            #1;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1 << vt[v].id);
            step();
            req_val = '0;
            check($sformatf("vec%0d_drop", v), 32'(drop), 32'(vt[v].drop));
            check($sformatf("vec%0d_ser_val", v), 32'(ser_val), 32'(!vt[v].drop));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(!vt[v].drop));
            if (!vt[v].drop) begin
                check($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vt[v].id));
                cnt = 0; hold_ok = 1'b1;
                while (busy && cnt < 40) begin
                    step();
                    if (busy) begin
                        cnt++;
                        if (ser_data !== vt[v].data || ser_mod !== vt[v].mod || grant_id !== 2'(vt[v].id) || ser_val)
                            hold_ok = 1'b0;
                    end
                end
                check($sformatf("vec%0d_wait_cycles", v), 32'(cnt), 32'(vt[v].wait_n));
                check($sformatf("vec%0d_hold", v), 32'(hold_ok), 32'd1);
            end else begin
                step();
                check($sformatf("vec%0d_drop_one_cycle", v), 32'(drop), 32'd0);
            end
        end

        // Reset three cycles into an issue abandons the word
        wait_idle("rstmid_pre");
        req_val = 4'b0100; req_data[2] = 16'hBEEF; req_mod[2] = 4'd0;
        step();
        req_val = '0;
        step(); step(); step();
        arst_n = 1'b0;
        req_val = 4'b1001;
        req_data[0] = 16'h0F0F; req_mod[0] = 4'd3;
        req_data[3] = 16'h7777; req_mod[3] = 4'd3;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ser_val", 32'(ser_val), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd0);
        check("rstmid_grant_id", 32'(grant_id), 32'd0);
        check("rstmid_ser_data", 32'(ser_data), 32'd0);
        check("rstmid_ser_mod", 32'(ser_mod), 32'd0);
        check("rstmid_drop", 32'(drop), 32'd0);
        step(); step(); step();
        arst_n = 1'b1;
        #1;
        check("rstmid_first_ready", 32'(req_ready), 32'b0001);
        step();
        req_val = '0;
        check("rstmid_ser_val_after", 32'(ser_val), 32'd1);
        check("rstmid_grant_after", 32'(grant_id), 32'd0);
        wait_idle("rstmid_post");

        // All four continuously valid: order and strobe spacing
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_data[i] = 16'h1000 + 16'(i);
            req_mod[i]  = 4'd4;
        end
        req_val = '1;
        np = 0; cy = 0;
        while (np < 5 && cy < 100) begin
            if (ser_val) begin
                got_ids[np] = int'(grant_id);
                got_cyc[np] = cy;
                np++;
                if (np == 5) req_val = '0;
            end
            if (np < 5) begin
                step();
                cy++;
            end
        end
        check("rr_pulse_count", 32'(np), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_order%0d", k), 32'(got_ids[k]), 32'(exp_ids[k]));
            if (k > 0) check($sformatf("rr_spacing%0d", k), 32'(got_cyc[k] - got_cyc[k-1]), 32'd6);
        end
        wait_idle("rr_post");

        // Illegal mod from requester 1 with requester 2 pending
        req_val = 4'b0110;
        req_data[1] = 16'hFFFF; req_mod[1] = 4'd2;
        req_data[2] = 16'h2222; req_mod[2] = 4'd5;
        #1;
        check("ill_ready1", 32'(req_ready), 32'b0010);
        step();
        req_val = 4'b0100;
        #1;
        check("ill_drop", 32'(drop), 32'd1);
        check("ill_no_ser_val", 32'(ser_val), 32'd0);
        check("ill_ready2", 32'(req_ready), 32'b0100);
        step();
        req_val = '0;
        check("ill_ser_val2", 32'(ser_val), 32'd1);
        check("ill_grant2", 32'(grant_id), 32'd2);
        check("ill_drop_cleared", 32'(drop), 32'd0);
        wait_idle("ill_post");

        // Late requester 3 arrives during requester 1's wait
        req_val = 4'b0010; req_data[1] = 16'h3333; req_mod[1] = 4'd3;
        #1;
        check("late_ready1", 32'(req_ready), 32'b0010);
        step();
        req_val = '0;
        step();
        req_val = 4'b1001;
        req_data[0] = 16'h4444; req_mod[0] = 4'd3;
        req_data[3] = 16'h5555; req_mod[3] = 4'd4;
        acc_ready = '0; cnt = 0;
        #1;
        while (busy && cnt < 40) begin
            acc_ready |= req_ready;
            step();
            cnt++;
        end
        check("late_no_ready_in_wait", 32'(acc_ready), 32'd0);
        check("late_ready3_first", 32'(req_ready), 32'b1000);
        step();
        req_val = 4'b0001;
        check("late_grant3", 32'(grant_id), 32'd3);
        wait_idle("late_mid");
        check("late_ready0_next", 32'(req_ready), 32'b0001);
        step();
        req_val = '0;
        check("late_grant0", 32'(grant_id), 32'd0);
        wait_idle("late_post");
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
